// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters; optional ALU_ARB_STATS_EN adds transfer counters.
// Latency: 1 cycle from transfer to res_valid. The result stage is one entry deep.
// Backpressure: both readies drop while a held result is not being taken; a drain and a refill can happen on the same edge.
module alu_arbiter #(
    parameter int   TAG_W   = 4,
    parameter logic RR_INIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r0_b,
    input  logic [3:0]       r0_op,
    input  logic [TAG_W-1:0] r0_tag,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r1_b,
    input  logic [3:0]       r1_op,
    input  logic [TAG_W-1:0] r1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [15:0]      stat_grant0,
    output logic [15:0]      stat_grant1,
    output logic [15:0]      stat_conflict
`endif
);

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'b0001: r = a << b[4:0];
            4'b0010: r = a + b;
            4'b0100: r = a - b;
            4'b0101: r = {31'd0, (a < b)};
            4'b0110: r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             res_src_q, res_src_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             last_grant_q, last_grant_d;

    logic             gnt0, gnt1, can_accept, xfer;
    logic [31:0]      sel_a, sel_b, alu_out;
    logic [3:0]       sel_op;
    logic [TAG_W-1:0] sel_tag;

    // On a tie the requester that did not win last time gets the ALU.
    assign gnt0       = r0_valid && (!r1_valid || last_grant_q);
    assign gnt1       = r1_valid && (!r0_valid || !last_grant_q);
    assign can_accept = !res_valid_q || res_ready;

    assign r0_ready = gnt0 && can_accept && !rst;
    assign r1_ready = gnt1 && can_accept && !rst;
    assign xfer     = (r0_valid && r0_ready) || (r1_valid && r1_ready);

    assign sel_a   = gnt1 ? r1_a   : r0_a;
    assign sel_b   = gnt1 ? r1_b   : r0_b;
    assign sel_op  = gnt1 ? r1_op  : r0_op;
    assign sel_tag = gnt1 ? r1_tag : r0_tag;
    assign alu_out = alu(sel_a, sel_b, sel_op);

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_src_d    = res_src_q;
        res_tag_d    = res_tag_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            res_valid_d  = 1'b1;
            res_data_d   = alu_out;
            res_src_d    = gnt1;
            res_tag_d    = sel_tag;
            last_grant_d = gnt1;
        end else if (res_ready) begin
            res_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= 32'd0;
            res_src_q    <= 1'b0;
            res_tag_q    <= '0;
            last_grant_q <= RR_INIT;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_src_q    <= res_src_d;
            res_tag_q    <= res_tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_src   = res_src_q;
    assign res_tag   = res_tag_q;

`ifdef ALU_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] stat_grant0_q, stat_grant0_d;
    logic [15:0] stat_grant1_q, stat_grant1_d;
    logic [15:0] stat_conflict_q, stat_conflict_d;

    // Clear takes priority over any event counted in the same cycle.
    always_comb begin
        stat_grant0_d   = sat_inc(stat_grant0_q, r0_valid && r0_ready);
        stat_grant1_d   = sat_inc(stat_grant1_q, r1_valid && r1_ready);
        stat_conflict_d = sat_inc(stat_conflict_q, r0_valid && r1_valid && xfer);
        if (stat_clr) begin
            stat_grant0_d   = 16'd0;
            stat_grant1_d   = 16'd0;
            stat_conflict_d = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant0_q   <= 16'd0;
            stat_grant1_q   <= 16'd0;
            stat_conflict_q <= 16'd0;
        end else begin
            stat_grant0_q   <= stat_grant0_d;
            stat_grant1_q   <= stat_grant1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance (32-bit, 4-bit control) between two requesters: requester 0 is the main execute pipe, requester 1 is the address/branch unit.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Registers the ALU result, together with its source ID and tag, into a one-entry output stage with backpressure.
- Sits between the decode/issue logic and writeback.

Parameters:
- TAG_W, 4, width of the requester tag carried through to the result.
- RR_INIT, 1, reset value of the last-grant pointer; 1 means requester 0 wins the first tie.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- r0_valid  input  1  requester 0 has an operation.
- r0_ready  output  1  requester 0 operation accepted this cycle.
- r0_a  input  32  operand 1 (ALU inp1).
- r0_b  input  32  operand 2 (ALU inp2).
- r0_op  input  4  ALU control code.
- r0_tag  input  TAG_W  opaque tag returned with the result.
- r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_tag: same directions, widths and meanings for requester 1.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer takes the result.
- res_data  output  32  ALU result.
- res_src  output  1  requester ID that produced the result.
- res_tag  output  TAG_W  tag of that operation.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst): res_valid=0, res_data=0, res_src=0, res_tag=0, last_grant=RR_INIT.
- r0_ready and r1_ready are 0 while rst is high.
- can_accept = !res_valid || res_ready.
- Grant, combinational:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
- rX_ready = granted(X) && can_accept. At most one ready is high in any cycle.
- Ready may depend combinationally on valid. Valid must not depend on ready.
- Transfer = rX_valid && rX_ready. On a transfer, at the next rising edge:
  - res_data = ALU(rX_a, rX_b, rX_op).
  - res_src = X; res_tag = rX_tag; res_valid = 1; last_grant = X.
- last_grant changes only on a transfer. Cycles with a valid request but no transfer do not rotate priority.
- Latency: exactly 1 cycle from transfer to res_valid.
- Throughput: 1 operation per cycle while res_ready is held high.
- Drain without refill (res_valid && res_ready, no transfer): res_valid goes to 0. res_data, res_src and res_tag hold their last values.
- Simultaneous drain and transfer: the new result replaces the old one in the same edge and res_valid stays 1. No bubble.
- Backpressure (res_valid && !res_ready):
  - Both readies are 0.
  - The result register and last_grant hold.
- Requester rules: once rX_valid is asserted, rX_a, rX_b, rX_op and rX_tag stay stable and rX_valid stays high until the transfer.
- Opcode handling: rX_op is passed to the ALU unchanged.
  - 0001 = shift left logical.
  - 0010 = add.
  - 0100 = subtract.
  - 0101 = unsigned set-less-than.
  - 0110 = xor.
  - Any other code returns operand 1.
- Arithmetic is 32-bit modulo 2^32. Carries and borrows are discarded.
- Reset asserted mid-operation: a pending result is discarded and not replayed; requesters re-present after reset.
- Starvation bound: a continuously valid requester is accepted within 2 output-register drains.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, three extra outputs are added, all reset to 0:
  - stat_grant0, 16 bits: counts requester-0 transfers.
  - stat_grant1, 16 bits: counts requester-1 transfers.
  - stat_conflict, 16 bits: counts cycles with both valid and a transfer occurring.
- All three counters saturate at 16'hFFFF and do not wrap.
- Input stat_clr (1 bit) zeroes all three counters synchronously. If stat_clr and a counting event occur in the same cycle, clear wins.
- When the macro is not defined, these ports and the counter logic are absent, and arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then r0 only: a=5, b=7, op=0010, tag=3, res_ready=1 -> r0_ready=1 in the same cycle; next cycle res_valid=1, res_data=12, res_src=0, res_tag=3.
- Both valid from reset:
  - r0: a=9, b=4, op=0100.
  - r1: a=1, b=4, op=0001.
  - res_ready=1.
  - Required: r0 granted first (res_data=5), then r1 (res_data=16), then alternating on every cycle while both stay valid.
- Backpressure:
  - Hold res_ready=0 with a result pending (a=3, b=8, op=0101 -> res_data=1).
  - Keep r1_valid=1 throughout.
  - Required: r1_ready=0 and res_data=1 held for 3 cycles.
  - Raise res_ready: r1 is accepted that cycle and the new result appears the next cycle with no bubble.
- Wrap and default opcode:
  - a=FFFFFFFF, b=1, op=0010 -> res_data=0.
  - a=A5A5A5A5, b=0, op=1111 -> res_data=A5A5A5A5.
- Reset mid-operation: assert rst while res_valid=1 -> res_valid=0 immediately and both readies 0; after release, the first tie goes to r0.
- ALU_ARB_STATS_EN build:
  - 70000 r0-only transfers -> stat_grant0=FFFF, saturated.
  - stat_clr pulse coinciding with a transfer -> all three counters read 0 the next cycle.
